// File: rtl/color_mask_pkg.sv
// color_mask_pkg: shared types for the colour-dominance masker.
// Config struct, colour/mode enums and the colour decode helper.
package color_mask_pkg;

    localparam int CFG_TH_W = 16;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        RED   = 3'd1,
        GREEN = 3'd2,
        BLUE  = 3'd3
    } color_e;

    typedef enum logic {
        BINARY = 1'b0,
        GRADED = 1'b1
    } mask_mode_e;

    typedef struct packed {
        color_e                color;
        logic [CFG_TH_W-1:0]   thresh;
        mask_mode_e            mode;
    } cfg_t;

    // Codes 4..7 are folded onto NONE so they can never match.
    function automatic color_e to_color(input logic [2:0] code);
        color_e c;
        case (code)
            3'd1:    c = RED;
            3'd2:    c = GREEN;
            3'd3:    c = BLUE;
            default: c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/color_mask_pipe_dominance.sv
// color_dominance: per-channel dominance over the mean of the
// other two channels, signed CH_W+1 bits, no wrap.
module color_dominance
    import color_mask_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0]        r,
    input  logic [CH_W-1:0]        g,
    input  logic [CH_W-1:0]        b,
    output logic signed [CH_W:0]   diff_r,
    output logic signed [CH_W:0]   diff_g,
    output logic signed [CH_W:0]   diff_b
);

    function automatic logic signed [CH_W:0] dom(
        input logic [CH_W-1:0] c,
        input logic [CH_W-1:0] o1,
        input logic [CH_W-1:0] o2
    );
        logic [CH_W:0] half;
        half = ({1'b0, o1} + {1'b0, o2}) >> 1;
        return $signed({1'b0, c}) - $signed(half);
    endfunction

    assign diff_r = dom(r, g, b);
    assign diff_g = dom(g, r, b);
    assign diff_b = dom(b, r, g);

endmodule

// File: rtl/color_mask_pipe.sv
// color_mask_pipe: two-stage RGB colour-dominance mask pipeline.
// Define COLOR_MASK_STATS_EN to build the per-frame match counter.
module color_mask_pipe
    import color_mask_pkg::*;
#(
    parameter int CH_W  = 4,
    parameter int CNT_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*CH_W-1:0] pixel_in,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [2:0]        parcel_color,
    input  logic [CH_W-1:0]   thresh,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   pixel_out,
    output logic              out_sof,
    output logic              out_eof,
    output logic [CNT_W-1:0]  match_count,
    output logic              stats_valid
);

    logic adv;
    cfg_t cfg_q, cfg_d, cfg_in;
    logic signed [CH_W:0] dr, dg, db;

    logic s1_valid_q, s1_valid_d;
    logic s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
    cfg_t s1_cfg_q, s1_cfg_d;
    logic signed [CH_W:0] s1_dr_q, s1_dr_d;
    logic signed [CH_W:0] s1_dg_q, s1_dg_d;
    logic signed [CH_W:0] s1_db_q, s1_db_d;

    logic out_valid_q, out_valid_d;
    logic [CH_W-1:0] pix_q, pix_d;
    logic sof_q, sof_d, eof_q, eof_d;

    logic signed [CH_W:0] diff_sel;
    logic signed [CFG_TH_W:0] d_ext, th_ext;
    logic hit;
    logic [CH_W-1:0] mask;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    color_dominance #(.CH_W(CH_W)) u_dom (
        .r      (pixel_in[3*CH_W-1 -: CH_W]),
        .g      (pixel_in[2*CH_W-1 -: CH_W]),
        .b      (pixel_in[CH_W-1:0]),
        .diff_r (dr),
        .diff_g (dg),
        .diff_b (db)
    );

    // An sof beat uses its own config; later beats use the latched one.
    always_comb begin
        cfg_in = cfg_q;
        if (in_sof) begin
            cfg_in.color  = to_color(parcel_color);
            cfg_in.thresh = CFG_TH_W'(thresh);
            cfg_in.mode   = mask_mode_e'(mode);
        end
    end

    // S2 compare: pick the selected diff and form the mask value.
    always_comb begin
        diff_sel = '0;
        hit      = 1'b0;
        th_ext   = $signed({1'b0, s1_cfg_q.thresh});
        d_ext    = '0;
        mask     = '0;
        unique case (s1_cfg_q.color)
            RED:     diff_sel = s1_dr_q;
            GREEN:   diff_sel = s1_dg_q;
            BLUE:    diff_sel = s1_db_q;
            default: diff_sel = '0;
        endcase
        d_ext = (CFG_TH_W+1)'(diff_sel);
        hit   = (s1_cfg_q.color != NONE) && (d_ext > th_ext);
        if (hit) begin
            mask = (s1_cfg_q.mode == BINARY) ? '1
                                             : diff_sel[CH_W-1:0];
        end
    end

    // Pipe advance: load both stages when adv, otherwise hold.
    always_comb begin
        cfg_d       = cfg_q;
        s1_valid_d  = s1_valid_q;
        s1_sof_d    = s1_sof_q;
        s1_eof_d    = s1_eof_q;
        s1_cfg_d    = s1_cfg_q;
        s1_dr_d     = s1_dr_q;
        s1_dg_d     = s1_dg_q;
        s1_db_d     = s1_db_q;
        out_valid_d = out_valid_q;
        pix_d       = pix_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        if (adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sof_d = in_sof;
                s1_eof_d = in_eof;
                s1_cfg_d = cfg_in;
                s1_dr_d  = dr;
                s1_dg_d  = dg;
                s1_db_d  = db;
                if (in_sof) begin
                    cfg_d = cfg_in;
                end
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pix_d = mask;
                sof_d = s1_sof_q;
                eof_d = s1_eof_q;
            end
        end
    end

    // Pipeline and config registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_cfg_q    <= '0;
            s1_dr_q     <= '0;
            s1_dg_q     <= '0;
            s1_db_q     <= '0;
            out_valid_q <= 1'b0;
            pix_q       <= '0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            s1_valid_q  <= s1_valid_d;
            s1_sof_q    <= s1_sof_d;
            s1_eof_q    <= s1_eof_d;
            s1_cfg_q    <= s1_cfg_d;
            s1_dr_q     <= s1_dr_d;
            s1_dg_q     <= s1_dg_d;
            s1_db_q     <= s1_db_d;
            out_valid_q <= out_valid_d;
            pix_q       <= pix_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign pixel_out = pix_q;
    assign out_sof   = sof_q;
    assign out_eof   = eof_q;

`ifdef COLOR_MASK_STATS_EN
    logic match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, mc_q, mc_d, base, nxt;
    logic sv_q, sv_d;

    // Saturating per-frame count of matched output beats.
    always_comb begin
        match_d = match_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        sv_d    = 1'b0;
        base    = '0;
        nxt     = '0;
        if (adv && s1_valid_q) begin
            match_d = hit;
        end
        if (out_valid_q && out_ready) begin
            base = sof_q ? '0 : cnt_q;
            nxt  = (match_q && !(&base)) ? base + CNT_W'(1) : base;
            if (eof_q) begin
                mc_d  = nxt;
                sv_d  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = nxt;
            end
        end
    end

    // Stats registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            cnt_q   <= '0;
            mc_q    <= '0;
            sv_q    <= 1'b0;
        end else begin
            match_q <= match_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            sv_q    <= sv_d;
        end
    end

    assign match_count = mc_q;
    assign stats_valid = sv_q;
`else
    assign match_count = '0;
    assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_color_mask_pipe.sv
// tb_color_mask_pipe: randomized self-checking bench for
// color_mask_pipe against a behavioural dominance model.
module tb_color_mask_pipe;

    typedef struct packed {
        logic [3:0] pix;
        logic       sof;
        logic       eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] pixel_in;
    logic        in_sof;
    logic        in_eof;
    logic [2:0]  parcel_color;
    logic [3:0]  thresh;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  pixel_out;
    logic        out_sof;
    logic        out_eof;
    logic [19:0] match_count;
    logic        stats_valid;

    int checks = 0;
    int errors = 0;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    exp_st_q[$];
    int    obs_st_q[$];

    int m_color = 0;
    int m_thr   = 0;
    int m_mode  = 0;
    int m_cnt   = 0;

    color_mask_pipe #(.CH_W(4), .CNT_W(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pixel_in     (pixel_in),
        .in_sof       (in_sof),
        .in_eof       (in_eof),
        .parcel_color (parcel_color),
        .thresh       (thresh),
        .mode         (mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pixel_out    (pixel_out),
        .out_sof      (out_sof),
        .out_eof      (out_eof),
        .match_count  (match_count),
        .stats_valid  (stats_valid)
    );

    always #5 clk = ~clk;

    // Dominance of the chosen channel over the mean of the other two.
    function automatic beat_t model(input logic [11:0] p, input int col,
                                    input int thr, input int md,
                                    input logic s, input logic e,
                                    output bit hit);
        int r, g, b, d;
        beat_t o;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        case (col)
            1:       d = r - (g + b) / 2;
            2:       d = g - (r + b) / 2;
            3:       d = b - (r + g) / 2;
            default: d = -100;
        endcase
        hit   = (d > thr);
        o.pix = hit ? (md != 0 ? 4'(d) : 4'hF) : 4'h0;
        o.sof = s;
        o.eof = e;
        return o;
    endfunction

    // Records accepted inputs (as model expectations) and outputs.
    always @(negedge clk) begin : mon
        beat_t b;
        bit hit;
        if (!rst_n) begin
            exp_q.delete();
            obs_q.delete();
            exp_st_q.delete();
            obs_st_q.delete();
            m_color = 0;
            m_thr   = 0;
            m_mode  = 0;
            m_cnt   = 0;
        end else begin
            if (in_valid && in_ready) begin
                if (in_sof) begin
                    m_color = int'(parcel_color);
                    m_thr   = int'(thresh);
                    m_mode  = int'(mode);
                    m_cnt   = 0;
                end
                b = model(pixel_in, m_color, m_thr, m_mode,
                          in_sof, in_eof, hit);
                exp_q.push_back(b);
                if (hit) m_cnt++;
                if (in_eof) begin
                    exp_st_q.push_back(m_cnt);
                    m_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                b.pix = pixel_out;
                b.sof = out_sof;
                b.eof = out_eof;
                obs_q.push_back(b);
            end
            if (stats_valid) obs_st_q.push_back(int'(match_count));
        end
    end

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        exp_st_q.delete();
        obs_st_q.delete();
    endtask

    task automatic put(input logic [11:0] p, input logic s, input logic e,
                       input logic [2:0] c, input logic [3:0] t,
                       input logic m);
        int n;
        n = 0;
        in_valid     = 1'b1;
        pixel_in     = p;
        in_sof       = s;
        in_eof       = e;
        parcel_color = c;
        thresh       = t;
        mode         = m;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL put_timeout in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks += 6;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", out_valid);
        end
        if (pixel_out !== 4'h0) begin
            errors++;
            $display("FAIL rst_pixel got %h want 0", pixel_out);
        end
        if (out_sof !== 1'b0 || out_eof !== 1'b0) begin
            errors++;
            $display("FAIL rst_sideband got %b%b want 00", out_sof, out_eof);
        end
        if (match_count !== 20'd0) begin
            errors++;
            $display("FAIL rst_match_count got %0d want 0", match_count);
        end
        if (stats_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stats_valid got %b want 0", stats_valid);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_binary();
        clear_q();
        put(12'hF00, 1'b1, 1'b0, 3'd1, 4'd2, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early out_valid got %b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || pixel_out !== 4'hF || out_sof !== 1'b1) begin
            errors++;
            $display("FAIL lat2 got v=%b p=%h s=%b want v=1 p=f s=1",
                     out_valid, pixel_out, out_sof);
        end
        @(posedge clk);
        #1;
        put(12'h888, 1'b0, 1'b0, 3'd1, 4'd2, 1'b0);
        put(12'h0FF, 1'b0, 1'b0, 3'd1, 4'd2, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 3 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL bin_count got %0d want 3", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[1].pix !== 4'h0) begin
                errors++;
                $display("FAIL bin_888 got %h want 0", obs_q[1].pix);
            end
            if (obs_q[2].pix !== 4'h0) begin
                errors++;
                $display("FAIL bin_0ff got %h want 0", obs_q[2].pix);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bin_beat%0d got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_graded();
        clear_q();
        put(12'h2A4, 1'b1, 1'b0, 3'd2, 4'd2, 1'b1);
        put(12'h585, 1'b0, 1'b0, 3'd2, 4'd2, 1'b1);
        for (int i = 0; i < 20; i++) begin
            put(12'($urandom), 1'b0, 1'b0, 3'd2, 4'd2, 1'b1);
        end
        drain();
        checks++;
        if (obs_q.size() != exp_q.size() || obs_q.size() != 22) begin
            errors++;
            $display("FAIL grad_count got %0d want 22", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].pix !== 4'h7) begin
                errors++;
                $display("FAIL grad_2a4 got %h want 7", obs_q[0].pix);
            end
            if (obs_q[1].pix !== 4'h3) begin
                errors++;
                $display("FAIL grad_585 got %h want 3", obs_q[1].pix);
            end
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL grad_beat%0d got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t held;
        clear_q();
        fork
            begin
                put(12'($urandom), 1'b1, 1'b0, 3'd3, 4'd1, 1'b1);
                for (int i = 0; i < 7; i++) begin
                    put(12'($urandom), 1'b0, i == 6, 3'd3, 4'd1, 1'b1);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held.pix = pixel_out;
                held.sof = out_sof;
                held.eof = out_eof;
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checks += 2;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_stall%0d rdy=%b v=%b want 0/1",
                                 k, in_ready, out_valid);
                    end
                    if ({pixel_out, out_sof, out_eof} !== held) begin
                        errors++;
                        $display("FAIL bp_hold%0d got %h want %h", k,
                                 {pixel_out, out_sof, out_eof}, held);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            errors++;
            $display("FAIL bp_count got %0d want 8", obs_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_beat%0d got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_cfg_change();
        clear_q();
        put(12'hF00, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0);
        put(12'hF00, 1'b0, 1'b0, 3'd3, 4'd15, 1'b1);
        put(12'h00F, 1'b0, 1'b0, 3'd3, 4'd0, 1'b0);
        put(12'h00F, 1'b1, 1'b0, 3'd3, 4'd0, 1'b0);
        put(12'hF00, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 5 || exp_q.size() != 5) begin
            errors++;
            $display("FAIL cfg_count got %0d want 5", obs_q.size());
        end else begin
            checks += 4;
            if (obs_q[1].pix !== 4'hF) begin
                errors++;
                $display("FAIL cfg_ignore got %h want f", obs_q[1].pix);
            end
            if (obs_q[2].pix !== 4'h0) begin
                errors++;
                $display("FAIL cfg_still_red got %h want 0", obs_q[2].pix);
            end
            if (obs_q[3].pix !== 4'hF) begin
                errors++;
                $display("FAIL cfg_new_blue got %h want f", obs_q[3].pix);
            end
            if (obs_q[4].pix !== 4'h0) begin
                errors++;
                $display("FAIL cfg_blue_kept got %h want 0", obs_q[4].pix);
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL cfg_beat%0d got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stats();
        clear_q();
        for (int i = 0; i < 10; i++) begin
            put((i % 3 == 0) ? 12'hF00 : 12'h000, i == 0, i == 9,
                3'd1, 4'd2, 1'b0);
        end
        put(12'hE11, 1'b1, 1'b1, 3'd1, 4'd2, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 11) begin
            errors++;
            $display("FAIL st_count got %0d want 11", obs_q.size());
        end
`ifdef COLOR_MASK_STATS_EN
        checks++;
        if (obs_st_q.size() != 2) begin
            errors++;
            $display("FAIL st_pulses got %0d want 2", obs_st_q.size());
        end else begin
            checks += 2;
            if (obs_st_q[0] != 4) begin
                errors++;
                $display("FAIL st_frame10 got %0d want 4", obs_st_q[0]);
            end
            if (obs_st_q[1] != 1) begin
                errors++;
                $display("FAIL st_single got %0d want 1", obs_st_q[1]);
            end
        end
`else
        checks += 2;
        if (obs_st_q.size() != 0) begin
            errors++;
            $display("FAIL st_off_pulses got %0d want 0", obs_st_q.size());
        end
        if (match_count !== 20'd0) begin
            errors++;
            $display("FAIL st_off_count got %0d want 0", match_count);
        end
`endif
    endtask

    task automatic test_random();
        bit done;
        int len;
        done = 1'b0;
        clear_q();
        fork
            begin
                for (int f = 0; f < 8; f++) begin
                    logic [2:0] c;
                    logic [3:0] t;
                    logic m;
                    c   = 3'($urandom_range(0, 7));
                    t   = 4'($urandom_range(0, 6));
                    m   = 1'($urandom);
                    len = $urandom_range(1, 12);
                    for (int i = 0; i < len; i++) begin
                        put(12'($urandom), i == 0, i == len - 1,
                            3'($urandom), 4'($urandom), 1'($urandom));
                        if (i == 0) begin
                            parcel_color = c;
                        end
                    end
                    put(12'($urandom), 1'b1, 1'b1, c, t, m);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_count got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd_beat%0d got %h want %h",
                             i, obs_q[i], exp_q[i]);
                end
            end
        end
`ifdef COLOR_MASK_STATS_EN
        checks++;
        if (obs_st_q.size() != exp_st_q.size()) begin
            errors++;
            $display("FAIL rnd_stats_n got %0d want %0d",
                     obs_st_q.size(), exp_st_q.size());
        end else begin
            for (int i = 0; i < obs_st_q.size(); i++) begin
                checks++;
                if (obs_st_q[i] != exp_st_q[i]) begin
                    errors++;
                    $display("FAIL rnd_stats%0d got %0d want %0d",
                             i, obs_st_q[i], exp_st_q[i]);
                end
            end
        end
`endif
    endtask

    task automatic test_reset_inflight();
        clear_q();
        put(12'hF00, 1'b1, 1'b0, 3'd1, 4'd0, 1'b0);
        put(12'hF00, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_fl_valid got %b want 0", out_valid);
        end
        if (pixel_out !== 4'h0) begin
            errors++;
            $display("FAIL rst_fl_pixel got %h want 0", pixel_out);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_fl_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        put(12'hF00, 1'b0, 1'b0, 3'd1, 4'd0, 1'b0);
        drain();
        checks++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL rst_fl_count got %0d want 1", obs_q.size());
        end else begin
            checks += 2;
            if (obs_q[0].pix !== 4'h0) begin
                errors++;
                $display("FAIL rst_fl_none got %h want 0", obs_q[0].pix);
            end
            if (obs_q[0] !== exp_q[0]) begin
                errors++;
                $display("FAIL rst_fl_beat got %h want %h",
                         obs_q[0], exp_q[0]);
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        pixel_in     = '0;
        in_sof       = 1'b0;
        in_eof       = 1'b0;
        parcel_color = '0;
        thresh       = '0;
        mode         = 1'b0;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        @(posedge clk);
        #1;
        test_binary();
        test_graded();
        test_backpressure();
        test_cfg_change();
        test_stats();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
